// File: rtl/apmu_csr_rmw_ctrl.sv
// Read-modify-write controller in front of a single CSR storage primitive.
// Latency: accept->write strobe 2 cycles, accept->response 3 (write) or 2 (read/error).
// Backpressure: one access in flight; req_ready_o low until the response handshakes.
module apmu_csr_rmw_ctrl #(
    parameter int                Width     = 32,
    parameter logic [Width-1:0]  WriteMask = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [Width-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             rsp_error_o,
    output logic             csr_wr_en_o,
    output logic [Width-1:0] csr_wr_data_o,
    input  logic [Width-1:0] csr_rd_data_i,
    input  logic             csr_rd_error_i,
    output logic             alert_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StCheck = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    localparam logic [1:0] OpRead  = 2'd0;
    localparam logic [1:0] OpWrite = 2'd1;
    localparam logic [1:0] OpSet   = 2'd2;
    localparam logic [1:0] OpClear = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q;
    logic [Width-1:0] wdata_q;
    logic [Width-1:0] old_q;
    logic [Width-1:0] new_q;
    logic             err_q;
    logic             alert_q;
    logic [Width-1:0] func_val;
    logic [Width-1:0] new_val;

    always_comb begin
        func_val = csr_rd_data_i;
        case (op_q)
            OpWrite: func_val = wdata_q;
            OpSet:   func_val = csr_rd_data_i | wdata_q;
            OpClear: func_val = csr_rd_data_i & ~wdata_q;
            default: func_val = csr_rd_data_i;
        endcase
    end

    assign new_val = (csr_rd_data_i & ~WriteMask) | (func_val & WriteMask);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req_valid_i) state_d = StCheck;
            StCheck: state_d = (csr_rd_error_i || op_q == OpRead) ? StResp : StWrite;
            StWrite: state_d = StResp;
            StResp:  if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            op_q    <= OpRead;
            wdata_q <= '0;
            old_q   <= '0;
            new_q   <= '0;
            err_q   <= 1'b0;
            alert_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid_i) begin
                op_q    <= req_op_i;
                wdata_q <= req_wdata_i;
            end
            if (state_q == StCheck) begin
                old_q <= csr_rd_data_i;
                new_q <= new_val;
                err_q <= csr_rd_error_i;
                if (csr_rd_error_i) alert_q <= 1'b1;
            end
        end
    end

    assign req_ready_o   = (state_q == StIdle);
    assign rsp_valid_o   = (state_q == StResp);
    assign rsp_rdata_o   = old_q;
    assign rsp_error_o   = err_q;
    // Gated by reset so a write caught in WRITE at the reset edge never lands.
    assign csr_wr_en_o   = (state_q == StWrite) && !rst_i;
    assign csr_wr_data_o = new_q;
    assign alert_o       = alert_q;

endmodule

// File: tb/tb_apmu_csr_rmw_ctrl.sv
// Bench for apmu_csr_rmw_ctrl with a behavioural CSR primitive and expectation queues.
module tb_apmu_csr_rmw_ctrl;

    localparam logic [31:0] MASK = 32'h0000_FFFF;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          wr_n;
        logic [31:0] wr_data;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_i;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] csr_q;
    logic        csr_err;
    logic        alert;
    logic        csr_load;
    logic [31:0] csr_load_val;

    int checks;
    int failures;

    exp_t        exp_q[$];
    logic [31:0] exp_wr_q[$];
    logic [31:0] exp_rsp_q[$];

    int          obs_wr_n;
    logic [31:0] obs_wr_data;
    int          obs_wr_cyc;
    int          obs_lat;
    logic [31:0] obs_rdata;
    logic        obs_err;

    apmu_csr_rmw_ctrl #(.Width(32), .WriteMask(MASK)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_error_o    (rsp_error),
        .csr_wr_en_o    (wr_en),
        .csr_wr_data_o  (wr_data),
        .csr_rd_data_i  (csr_q),
        .csr_rd_error_i (csr_err),
        .alert_o        (alert)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (csr_load)   csr_q <= csr_load_val;
        else if (wr_en) csr_q <= wr_data;
    end

    task automatic set_csr(input logic [31:0] v);
        csr_load = 1'b1;
        csr_load_val = v;
        @(negedge clk);
        csr_load = 1'b0;
    endtask

    // Drives one request from IDLE and records what the DUT does until the response handshakes.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] wd, input logic inj);
        obs_wr_n = 0; obs_wr_data = '0; obs_wr_cyc = -1; obs_lat = -1;
        obs_rdata = '0; obs_err = 1'b0;
        req_valid = 1'b1; req_op = op; req_wdata = wd; csr_err = inj; rsp_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (wr_en) begin
                obs_wr_n++;
                obs_wr_data = wr_data;
                obs_wr_cyc = c;
            end
            if (rsp_valid) begin
                obs_lat = c;
                obs_rdata = rsp_rdata;
                obs_err = rsp_error;
                break;
            end
        end
        @(negedge clk);
        csr_err = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_error, wr_en, wr_data, alert} !==
            {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b rdata=%h err=%b we=%b wd=%h alert=%b",
                     req_ready, rsp_valid, rsp_rdata, rsp_error, wr_en, wr_data, alert);
        end
    endtask

    task automatic test_ops;
        logic [1:0]  ops[5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        logic [31:0] wds[5]  = '{32'h0, 32'h1234_5678, 32'h0000_00F0, 32'h0000_000F, 32'h0};
        logic [31:0] olds[5] = '{32'hA5A5_0000, 32'hFFFF_0000, 32'h0000_000F, 32'h0000_00FF, 32'h0000_00F0};
        logic [31:0] news[5] = '{32'h0, 32'hFFFF_5678, 32'h0000_00FF, 32'h0000_00F0, 32'h0000_00F0};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            set_csr(olds[i]);
            e.rdata = olds[i]; e.err = 1'b0;
            e.wr_n = (ops[i] == 2'd0) ? 0 : 1;
            e.wr_data = news[i];
            e.lat = (ops[i] == 2'd0) ? 2 : 3;
            exp_q.push_back(e);
            run_txn(ops[i], wds[i], 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (obs_lat !== e.lat || obs_rdata !== e.rdata || obs_err !== e.err) begin
                failures++;
                $display("FAIL op%0d_rsp: lat=%0d rdata=%h err=%b, want lat=%0d rdata=%h err=%b",
                         i, obs_lat, obs_rdata, obs_err, e.lat, e.rdata, e.err);
            end
            checks++;
            if (obs_wr_n !== e.wr_n || (e.wr_n == 1 && (obs_wr_data !== e.wr_data || obs_wr_cyc !== 2))) begin
                failures++;
                $display("FAIL op%0d_write: n=%0d data=%h cyc=%0d, want n=%0d data=%h cyc=2",
                         i, obs_wr_n, obs_wr_data, obs_wr_cyc, e.wr_n, e.wr_data);
            end
            checks++;
            if (csr_q !== (e.wr_n == 1 ? e.wr_data : olds[i])) begin
                failures++;
                $display("FAIL op%0d_csr: csr=%h want %h", i, csr_q, (e.wr_n == 1 ? e.wr_data : olds[i]));
            end
        end
    endtask

    task automatic test_error;
        set_csr(32'h0000_00F0);
        run_txn(2'd1, 32'h0000_1234, 1'b1);
        checks++;
        if (obs_wr_n !== 0 || obs_err !== 1'b1 || obs_lat !== 2 || obs_rdata !== 32'h0000_00F0) begin
            failures++;
            $display("FAIL err_write: writes=%0d err=%b lat=%0d rdata=%h, want 0 1 2 000000f0",
                     obs_wr_n, obs_err, obs_lat, obs_rdata);
        end
        checks++;
        if (alert !== 1'b1 || csr_q !== 32'h0000_00F0) begin
            failures++;
            $display("FAIL err_alert: alert=%b csr=%h, want 1 000000f0", alert, csr_q);
        end
        run_txn(2'd0, 32'h0, 1'b0);
        checks++;
        if (alert !== 1'b1 || obs_err !== 1'b0) begin
            failures++;
            $display("FAIL alert_sticky: alert=%b err=%b, want 1 0", alert, obs_err);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_rd;
        int          seen;
        set_csr(32'hCAFE_0001);
        exp_rsp_q.push_back(32'hCAFE_0001);
        req_valid = 1'b1; req_op = 2'd0; req_wdata = '0; rsp_ready = 1'b0;
        seen = 0;
        for (int c = 1; c <= 20 && seen == 0; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) seen = 1;
        end
        exp_rd = exp_rsp_q.pop_front();
        checks++;
        if (seen != 1) begin
            failures++;
            $display("FAIL bp_rsp_timeout: rsp_valid=%b want 1", rsp_valid);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_rdata, rsp_error, req_ready, wr_en} !== {1'b1, exp_rd, 1'b0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d: vld=%b rdata=%h err=%b rdy=%b we=%b, want 1 %h 0 0 0",
                         k, rsp_valid, rsp_rdata, rsp_error, req_ready, wr_en, exp_rd);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: vld=%b rdy=%b, want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] wds[3] = '{32'h0000_1111, 32'hABCD_2222, 32'h0000_3333};
        logic [31:0] model;
        logic [31:0] e;
        int          acc_cyc[3];
        int          n_acc, n_rsp;
        logic        pending;
        set_csr(32'h0);
        model = 32'h0;
        n_acc = 0; n_rsp = 0; pending = 1'b0;
        req_valid = 1'b1; req_op = 2'd1; req_wdata = wds[0]; rsp_ready = 1'b1;
        for (int c = 0; c < 60 && n_rsp < 3; c++) begin
            if (pending) begin
                pending = 1'b0;
                n_acc++;
                if (n_acc < 3) req_wdata = wds[n_acc];
                else req_valid = 1'b0;
            end
            if (req_valid && req_ready) begin
                pending = 1'b1;
                acc_cyc[n_acc] = c;
                exp_rsp_q.push_back(model);
                model = (model & ~MASK) | (req_wdata & MASK);
                exp_wr_q.push_back(model);
            end
            @(negedge clk);
            if (wr_en) begin
                e = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : 32'hDEAD_BEEF;
                checks++;
                if (wr_data !== e) begin
                    failures++;
                    $display("FAIL b2b_wdata: got %h want %h", wr_data, e);
                end
            end
            if (rsp_valid) begin
                n_rsp++;
                e = (exp_rsp_q.size() > 0) ? exp_rsp_q.pop_front() : 32'hDEAD_BEEF;
                checks++;
                if (rsp_rdata !== e) begin
                    failures++;
                    $display("FAIL b2b_rdata: got %h want %h", rsp_rdata, e);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (n_rsp != 3 || exp_wr_q.size() != 0 || acc_cyc[1] - acc_cyc[0] != 4 || acc_cyc[2] - acc_cyc[1] != 4) begin
            failures++;
            $display("FAIL b2b_rate: rsps=%0d wr_left=%0d gaps=%0d,%0d want 3 0 4,4",
                     n_rsp, exp_wr_q.size(), acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
        end
        checks++;
        if (csr_q !== 32'h0000_3333) begin
            failures++;
            $display("FAIL b2b_csr: csr=%h want 00003333", csr_q);
        end
    endtask

    task automatic test_reset_in_write;
        set_csr(32'h0000_00AA);
        req_valid = 1'b1; req_op = 2'd1; req_wdata = 32'h0000_5555; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1) begin
            failures++;
            $display("FAIL rstw_in_write: we=%b want 1", wr_en);
        end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checks++;
        if ({wr_en, rsp_valid, req_ready, alert, rsp_rdata, wr_data} !== {1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL rstw_outputs: we=%b vld=%b rdy=%b alert=%b rdata=%h wd=%h, want 0 0 1 0 0 0",
                     wr_en, rsp_valid, req_ready, alert, rsp_rdata, wr_data);
        end
        checks++;
        if (csr_q !== 32'h0000_00AA) begin
            failures++;
            $display("FAIL rstw_csr: csr=%h want 000000aa", csr_q);
        end
        run_txn(2'd0, 32'h0, 1'b0);
        checks++;
        if (obs_rdata !== 32'h0000_00AA || obs_lat !== 2) begin
            failures++;
            $display("FAIL rstw_readback: rdata=%h lat=%0d want 000000aa 2", obs_rdata, obs_lat);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_i = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_wdata = '0;
        rsp_ready = 1'b1; csr_err = 1'b0; csr_load = 1'b1; csr_load_val = '0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0; csr_load = 1'b0;
        @(negedge clk);
        test_reset();
        test_ops();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_reset_in_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
